// File: rtl/control_fsm_pkg.sv
// Shared definitions for the control FSM and its datapath: state encoding,
// opcode values and ALU function selects.
package control_fsm_pkg;

   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOAD_A = 4'd4,
      S_LOAD_B = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   localparam logic [3:0] OP_NOOP  = 4'b0000;
   localparam logic [3:0] OP_STORE = 4'b0001;
   localparam logic [3:0] OP_LOAD  = 4'b0010;
   localparam logic [3:0] OP_ADD   = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0100;
   localparam logic [3:0] OP_HALT  = 4'b0101;

   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   // Undefined opcodes fall through to NOOP.
   function automatic state_t decode_opcode(input logic [3:0] op);
      state_t s;
      case (op)
         OP_NOOP:  s = S_NOOP;
         OP_STORE: s = S_STORE;
         OP_LOAD:  s = S_LOAD_A;
         OP_ADD:   s = S_ADD;
         OP_SUB:   s = S_SUB;
         OP_HALT:  s = S_HALT;
         default:  s = S_NOOP;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bus between the FSM (master) and the datapath (slave).
// Inst is the instruction register output; all other signals are driven by the FSM.
interface control_fsm_if;
   logic [15:0] Inst;
   logic        PC_clr;
   logic        PC_up;
   logic        IR_ld;
   logic [7:0]  D_addr;
   logic        D_wr;
   logic        RF_s;
   logic [3:0]  RF_W_addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  ALU_s0;
   logic [3:0]  OutState;

   modport master (
      input  Inst,
      output PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
             RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
   );

   modport slave (
      output Inst,
      input  PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, RF_W_addr, RF_W_en,
             RF_Ra_addr, RF_Rb_addr, ALU_s0, OutState
   );
endinterface

// File: rtl/control_fsm.sv
// Moore control FSM: fetch / decode / execute sequencing for a small processor.
// Outputs depend only on the state register and the current instruction word.
module control_fsm
   import control_fsm_pkg::*;
(
   input  logic          Clk,
   input  logic          ResetN,
   control_fsm_if.master bus
);

   state_t state_q, state_d;
   logic   run_q;

   // run_q holds INIT for one full clocked cycle after reset release,
   // so PC_clr is seen by an edge and the first FETCH lands on the second edge.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         state_q <= S_INIT;
         run_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         run_q   <= 1'b1;
      end
   end

   always_comb begin
      state_d        = state_q;
      bus.PC_clr     = 1'b0;
      bus.PC_up      = 1'b0;
      bus.IR_ld      = 1'b0;
      bus.D_addr     = 8'h00;
      bus.D_wr       = 1'b0;
      bus.RF_s       = 1'b0;
      bus.RF_W_addr  = 4'h0;
      bus.RF_W_en    = 1'b0;
      bus.RF_Ra_addr = 4'h0;
      bus.RF_Rb_addr = 4'h0;
      bus.ALU_s0     = ALU_PASS;

      case (state_q)
         S_INIT: begin
            bus.PC_clr = 1'b1;
            if (run_q) state_d = S_FETCH;
         end
         S_FETCH: begin
            bus.PC_up = 1'b1;
            bus.IR_ld = 1'b1;
            state_d   = S_DECODE;
         end
         S_DECODE: state_d = decode_opcode(bus.Inst[15:12]);
         S_NOOP:   state_d = S_FETCH;
         S_LOAD_A: begin
            bus.D_addr = bus.Inst[11:4];
            bus.RF_s   = 1'b1;
            state_d    = S_LOAD_B;
         end
         S_LOAD_B: begin
            bus.D_addr    = bus.Inst[11:4];
            bus.RF_s      = 1'b1;
            bus.RF_W_addr = bus.Inst[3:0];
            bus.RF_W_en   = 1'b1;
            state_d       = S_FETCH;
         end
         S_STORE: begin
            bus.D_addr     = bus.Inst[7:0];
            bus.RF_Ra_addr = bus.Inst[11:8];
            bus.D_wr       = 1'b1;
            state_d        = S_FETCH;
         end
         S_ADD, S_SUB: begin
            bus.RF_Ra_addr = bus.Inst[11:8];
            bus.RF_Rb_addr = bus.Inst[7:4];
            bus.RF_W_addr  = bus.Inst[3:0];
            bus.RF_W_en    = 1'b1;
            bus.ALU_s0     = (state_q == S_ADD) ? ALU_ADD : ALU_SUB;
            state_d        = S_FETCH;
         end
         S_HALT:  state_d = S_HALT;
         default: state_d = S_INIT;
      endcase
   end

   assign bus.OutState = state_q;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction through fetch/decode/execute
// and exercises asynchronous reset from mid-LOAD and from HALT.
module tb_control_fsm;
   import control_fsm_pkg::*;

   logic Clk;
   logic ResetN;
   int   tests;
   int   fails;
   int   pc_up_cnt;

   control_fsm_if bus ();

   control_fsm dut (
      .Clk    (Clk),
      .ResetN (ResetN),
      .bus    (bus.master)
   );

   // Clock/reset
   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   // Output bundle: {PC_clr, PC_up, IR_ld, D_addr, D_wr, RF_s, W_addr, W_en, Ra, Rb, ALU}
   logic [28:0] obs;
   assign obs = {bus.PC_clr, bus.PC_up, bus.IR_ld, bus.D_addr, bus.D_wr, bus.RF_s,
                 bus.RF_W_addr, bus.RF_W_en, bus.RF_Ra_addr, bus.RF_Rb_addr, bus.ALU_s0};

   function automatic logic [28:0] ov(input logic pc_clr, input logic pc_up, input logic ir_ld,
                                      input logic [7:0] d_addr, input logic d_wr, input logic rf_s,
                                      input logic [3:0] w_addr, input logic w_en,
                                      input logic [3:0] ra, input logic [3:0] rb,
                                      input logic [2:0] alu);
      return {pc_clr, pc_up, ir_ld, d_addr, d_wr, rf_s, w_addr, w_en, ra, rb, alu};
   endfunction

   task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Driver: advance to the next falling edge and check state plus outputs.
   task automatic cyc(input string tag, input state_t st, input logic [28:0] exp_out);
      @(negedge Clk);
      chk({tag, "_state"}, 32'(bus.OutState), 32'(st));
      chk({tag, "_out"}, 32'(obs), 32'(exp_out));
   endtask

   logic [28:0] o_init, o_fetch, o_zero;

   initial begin
      tests    = 0;
      fails    = 0;
      o_init   = ov(1, 0, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
      o_fetch  = ov(0, 1, 1, 8'h00, 0, 0, 4'h0, 0, 4'h0, 4'h0, 3'b000);
      o_zero   = '0;
      ResetN   = 1'b0;
      bus.Inst = 16'h0000;

      // Reset held, then release: one INIT cycle, then FETCH on the second edge
      cyc("in_reset", S_INIT, o_init);
      ResetN = 1'b1;
      cyc("init_after_release", S_INIT, o_init);
      cyc("fetch0", S_FETCH, o_fetch);
      cyc("decode0", S_DECODE, o_zero);
      cyc("noop0", S_NOOP, o_zero);
      cyc("fetch1", S_FETCH, o_fetch);

      // NOOP loop: PC_up once every 3 cycles
      pc_up_cnt = 0;
      for (int i = 0; i < 9; i++) begin
         @(negedge Clk);
         if (bus.PC_up) pc_up_cnt++;
      end
      chk("pc_up_rate", 32'(pc_up_cnt), 32'd3);
      chk("loop_end_state", 32'(bus.OutState), 32'(S_FETCH));

      // LOAD 0x21B5: 4-cycle instruction
      bus.Inst = 16'h21B5;
      cyc("load_dec", S_DECODE, o_zero);
      cyc("load_a", S_LOAD_A, ov(0, 0, 0, 8'h1B, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'b000));
      cyc("load_b", S_LOAD_B, ov(0, 0, 0, 8'h1B, 0, 1, 4'h5, 1, 4'h0, 4'h0, 3'b000));
      cyc("load_ret", S_FETCH, o_fetch);

      // ADD 0x3A3C
      bus.Inst = 16'h3A3C;
      cyc("add_dec", S_DECODE, o_zero);
      cyc("add", S_ADD, ov(0, 0, 0, 8'h00, 0, 0, 4'hC, 1, 4'hA, 4'h3, 3'b001));
      cyc("add_ret", S_FETCH, o_fetch);

      // SUB 0x4A3C
      bus.Inst = 16'h4A3C;
      cyc("sub_dec", S_DECODE, o_zero);
      cyc("sub", S_SUB, ov(0, 0, 0, 8'h00, 0, 0, 4'hC, 1, 4'hA, 4'h3, 3'b010));
      cyc("sub_ret", S_FETCH, o_fetch);

      // STORE 0x1742: D_wr for exactly one cycle
      bus.Inst = 16'h1742;
      cyc("store_dec", S_DECODE, o_zero);
      cyc("store", S_STORE, ov(0, 0, 0, 8'h42, 1, 0, 4'h0, 0, 4'h7, 4'h0, 3'b000));
      cyc("store_ret", S_FETCH, o_fetch);

      // Undefined opcode 0xF123 behaves as NOOP
      bus.Inst = 16'hF123;
      cyc("undef_dec", S_DECODE, o_zero);
      cyc("undef_noop", S_NOOP, o_zero);
      cyc("undef_ret", S_FETCH, o_fetch);

      // Reset asserted mid-cycle during LOAD_A
      bus.Inst = 16'h21B5;
      cyc("rl_dec", S_DECODE, o_zero);
      cyc("rl_load_a", S_LOAD_A, ov(0, 0, 0, 8'h1B, 0, 1, 4'h0, 0, 4'h0, 4'h0, 3'b000));
      #2 ResetN = 1'b0;
      #1;
      chk("rl_async_state", 32'(bus.OutState), 32'(S_INIT));
      chk("rl_async_out", 32'(obs), 32'(o_init));
      cyc("rl_held", S_INIT, o_init);
      ResetN = 1'b1;
      cyc("rl_init", S_INIT, o_init);
      cyc("rl_fetch", S_FETCH, o_fetch);

      // HALT 0x5000: stays put for 20 cycles
      bus.Inst = 16'h5000;
      cyc("halt_dec", S_DECODE, o_zero);
      for (int i = 0; i < 20; i++) begin
         cyc($sformatf("halt%0d", i), S_HALT, o_zero);
      end

      // Reset asserted mid-cycle while halted
      #7 ResetN = 1'b0;
      #1;
      chk("rh_async_state", 32'(bus.OutState), 32'(S_INIT));
      chk("rh_async_out", 32'(obs), 32'(o_init));
      @(negedge Clk);
      ResetN = 1'b1;
      cyc("rh_init", S_INIT, o_init);
      cyc("rh_fetch", S_FETCH, o_fetch);
      cyc("rh_dec", S_DECODE, o_zero);
      cyc("rh_halt", S_HALT, o_zero);

      // Report
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
